fp_addsub_pipe: RTL

- Pipelined IEEE-754 floating-point adder/subtractor; parametrised successor of the single-cycle add wrapper.
- Adds an add/sub op select, valid/ready handshake on both sides and a fixed 4-stage pipeline (align, add, normalise, round).
- Sits between the FPU operand/issue logic and the result writeback. Sustains one operation per clock when not back-pressured.

---
 rtl/fp_addsub_pipe.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 4-stage (align/add/normalise/round) IEEE-754 adder/subtractor with valid/ready
// Optional FPADDSUB_STICKY_STATUS_EN adds clr_flags/flags_acc (status OR-accumulated over output transfers).
module fp_addsub_pipe #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic                         op,
  input  logic [2:0]                   rnd,
`ifdef FPADDSUB_STICKY_STATUS_EN
  input  logic                         clr_flags,
  output logic [7:0]                   flags_acc,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);
  localparam int SW = sig_width;
  localparam int EW = exp_width;
  localparam int W  = SW + EW + 1;
  localparam int MW = SW + 4;
  localparam int LW = $clog2(MW + 1);
  localparam logic [EW-1:0] EONES = '1;
  localparam logic [EW-1:0] EMAXF = {{(EW-1){1'b1}}, 1'b0};

  function automatic logic [LW-1:0] lzc(input logic [MW-1:0] v);
    lzc = LW'(MW);
    for (int i = 0; i < MW; i++)
      if (v[i]) lzc = LW'(MW - 1 - i);
  endfunction

  logic advance;
  logic s1_valid, s2_valid, s3_valid;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: unpack, specials, order by magnitude, align the smaller operand
  logic          sa, sb, nan_a, nan_b, inf_a, inf_b, swap, sx;
  logic [EW-1:0] ea, eb, ea_e, eb_e, ex, ey, ed;
  logic [SW-1:0] fa, fb, fa_f, fb_f;
  logic [MW-1:0] ma, mb, mx, my, my_al;
  logic [15:0]   ash;
  logic [2*MW-1:0] wide;

  always_comb begin
    sa    = a[W-1];
    ea    = a[W-2:SW];
    fa    = a[SW-1:0];
    sb    = b[W-1] ^ op;
    eb    = b[W-2:SW];
    fb    = b[SW-1:0];
    nan_a = (ea == EONES) && (fa != '0);
    nan_b = (eb == EONES) && (fb != '0);
    inf_a = (ea == EONES) && (fa == '0);
    inf_b = (eb == EONES) && (fb == '0);
    fa_f  = (ieee_compliance == 0 && ea == '0) ? '0 : fa;
    fb_f  = (ieee_compliance == 0 && eb == '0) ? '0 : fb;
    ea_e  = (ea == '0) ? EW'(1) : ea;
    eb_e  = (eb == '0) ? EW'(1) : eb;
    ma    = {ea != '0, fa_f, 3'b000};
    mb    = {eb != '0, fb_f, 3'b000};
    swap  = {eb, fb_f} > {ea, fa_f};
    sx    = swap ? sb : sa;
    ex    = swap ? eb_e : ea_e;
    ey    = swap ? ea_e : eb_e;
    mx    = swap ? mb : ma;
    my    = swap ? ma : mb;
    ed    = ex - ey;
    ash   = (16'(ed) > 16'(SW + 3)) ? 16'(SW + 3) : 16'(ed);
    wide  = {my, MW'(0)} >> ash;
    my_al = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
  end

  logic          s1_sign, s1_sub, s1_nan, s1_inf, s1_inf_sign;
  logic [EW:0]   s1_exp;
  logic [MW-1:0] s1_ma, s1_mb;
  logic [2:0]    s1_rnd;

  logic          s2_sign, s2_sub, s2_nan, s2_inf, s2_inf_sign;
  logic [EW:0]   s2_exp;
  logic [MW:0]   s2_sum;
  logic [2:0]    s2_rnd;

  // Stage 3: normalise, never pushing the exponent below 1
  logic [LW-1:0] lz;
  logic [15:0]   lim, nsh;
  logic [MW-1:0] nm;
  logic [EW:0]   ne;
  logic          nflush;

  always_comb begin
    lz  = lzc(s2_sum[MW-1:0]);
    lim = 16'(s2_exp) - 16'd1;
    nsh = (16'(lz) < lim) ? 16'(lz) : lim;
    if (s2_sum[MW]) begin
      nm = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
      ne = s2_exp + (EW+1)'(1);
    end else begin
      nm = s2_sum[MW-1:0] << nsh;
      ne = s2_exp - (EW+1)'(nsh);
    end
    if (!nm[MW-1]) ne = '0;
    nflush = (ieee_compliance == 0) && !nm[MW-1] && (s2_sum != '0);
  end

  logic          s3_sign, s3_sub, s3_nan, s3_inf, s3_inf_sign, s3_zero, s3_flush;
  logic [EW:0]   s3_exp;
  logic [MW-2:0] s3_m;
  logic [2:0]    s3_rnd;

  // Stage 4: round; denormals carry naturally into the exponent field
  logic           g, st, lsb, up, to_inf, ovf, zsign;
  logic [EW+SW:0] rs;
  logic [EW:0]    re;
  logic [SW-1:0]  rf;
  logic [W-1:0]   nz;
  logic [7:0]     nst;

  always_comb begin
    lsb = s3_m[3];
    g   = s3_m[2];
    st  = s3_m[1] | s3_m[0];
    case (s3_rnd)
      3'd1:    up = 1'b0;
      3'd2:    up = !s3_sign && (g || st);
      3'd3:    up = s3_sign && (g || st);
      3'd4:    up = g;
      default: up = g && (st || lsb);
    endcase
    case (s3_rnd)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = !s3_sign;
      3'd3:    to_inf = s3_sign;
      default: to_inf = 1'b1;
    endcase
    rs    = {s3_exp, s3_m[MW-2:3]} + (EW+SW+1)'(up);
    re    = rs[EW+SW:SW];
    rf    = rs[SW-1:0];
    ovf   = re >= {1'b0, EONES};
    zsign = s3_sub ? (s3_rnd == 3'd3) : s3_sign;
    nz    = '0;
    nst   = '0;
    if (s3_nan) begin
      nz     = {1'b0, EONES, 1'b1, (SW-1)'(0)};
      nst[2] = 1'b1;
    end else if (s3_inf) begin
      nz     = {s3_inf_sign, EONES, SW'(0)};
      nst[1] = 1'b1;
    end else if (s3_zero) begin
      nz     = {zsign, (W-1)'(0)};
      nst[0] = 1'b1;
    end else if (s3_flush) begin
      nz  = {s3_sign, (W-1)'(0)};
      nst = 8'h29;
    end else if (ovf) begin
      nz  = to_inf ? {s3_sign, EONES, SW'(0)} : {s3_sign, EMAXF, {SW{1'b1}}};
      nst = 8'h30;
    end else begin
      nz     = {s3_sign, re[EW-1:0], rf};
      nst[5] = g || st;
      nst[3] = (ieee_compliance != 0) && (re == '0);
      nst[0] = (re == '0) && (rf == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      z         <= '0;
      status    <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (s3_valid) begin
        z      <= nz;
        status <= nst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign     <= sx;
      s1_sub      <= sa ^ sb;
      s1_exp      <= {1'b0, ex};
      s1_ma       <= mx;
      s1_mb       <= my_al;
      s1_nan      <= nan_a || nan_b || (inf_a && inf_b && (sa != sb));
      s1_inf      <= inf_a || inf_b;
      s1_inf_sign <= inf_a ? sa : sb;
      s1_rnd      <= rnd;

      s2_sign     <= s1_sign;
      s2_sub      <= s1_sub;
      s2_exp      <= s1_exp;
      s2_sum      <= s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
      s2_nan      <= s1_nan;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
      s2_rnd      <= s1_rnd;

      s3_sign     <= s2_sign;
      s3_sub      <= s2_sub;
      s3_exp      <= ne;
      s3_m        <= nm[MW-2:0];
      s3_zero     <= (s2_sum == '0);
      s3_flush    <= nflush;
      s3_nan      <= s2_nan;
      s3_inf      <= s2_inf;
      s3_inf_sign <= s2_inf_sign;
      s3_rnd      <= s2_rnd;
    end
  end

`ifdef FPADDSUB_STICKY_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) flags_acc <= '0;
    else        flags_acc <= (clr_flags ? 8'h00 : flags_acc) | ((out_valid && out_ready) ? status : 8'h00);
  end
`endif

endmodule
